// File: rtl/merge_pkg.sv
// Shared definitions for the 2-to-1 stream merge: default data width,
// source encodings carried on out_src, and the output register states.
package merge_pkg;

    localparam int DW_DEFAULT = 10;

    localparam logic SRC_1 = 1'b0;
    localparam logic SRC_2 = 1'b1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/merge_2_to_1_10bits_arb_2.sv
// Two-way arbiter for the stream merge.
// Build option MERGE_RR_ARB_EN: when defined, contention is resolved
// round-robin using a last-grant pointer; otherwise source 1 (req[0])
// always wins and no pointer register exists.
// The advance input is the pointer-update strobe: it is high only in cycles
// where a word is actually transferred, so the pointer never moves when a
// granted source is stalled behind a full output register.
module arb_2
    import merge_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

`ifdef MERGE_RR_ARB_EN

    logic last_gnt;
    logic prefer_1;

    assign prefer_1 = (last_gnt == SRC_2);

    // One-hot grant: a lone requester always wins, a tie goes to the source
    // that was not granted most recently.
    always_comb begin
        gnt    = 2'b00;
        gnt[0] = req[0] & (~req[1] | prefer_1);
        gnt[1] = req[1] & (~req[0] | ~prefer_1);
    end

    // Remember which source won the last real transfer; reset points at
    // source 2 so source 1 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= SRC_2;
        end else if (advance) begin
            last_gnt <= gnt[1] ? SRC_2 : SRC_1;
        end
    end

`else

    // Fixed priority keeps no history, so the clock, reset and update strobe
    // are intentionally left unused in this build.
    logic unused_ptr_inputs;
    assign unused_ptr_inputs = &{1'b0, clk, rst_n, advance};

    // One-hot grant with source 1 always winning a tie.
    always_comb begin
        gnt    = 2'b00;
        gnt[0] = req[0];
        gnt[1] = req[1] & ~req[0];
    end

`endif

endmodule

// File: rtl/merge_2_to_1_10bits.sv
// Merges two valid/ready streams into one through a single output register.
// Arbitration between simultaneous requests is done in arb_2; the build
// option MERGE_RR_ARB_EN selects round-robin there, fixed priority (source 1
// wins) otherwise.
// The input readies depend only on the input valids, the register state and
// out_ready, never on the data buses.
module merge_2_to_1_10bits
    import merge_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          in1_valid,
    output logic          in1_ready,
    input  logic [DW-1:0] in1_data,

    input  logic          in2_valid,
    output logic          in2_ready,
    input  logic [DW-1:0] in2_data,

    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_src
);

    state_t     state;
    logic       reg_free;
    logic [1:0] gnt;
    logic       acc_1;
    logic       acc_2;
    logic       accept;

    // The register can take a new word when it is empty or is being drained
    // in this very cycle.
    assign reg_free  = (state == EMPTY) || out_ready;

    assign in1_ready = reg_free & gnt[0];
    assign in2_ready = reg_free & gnt[1];

    assign acc_1     = in1_valid & in1_ready;
    assign acc_2     = in2_valid & in2_ready;
    assign accept    = acc_1 | acc_2;

    assign out_valid = (state == FULL);

    arb_2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({in2_valid, in1_valid}),
        .advance (accept),
        .gnt     (gnt)
    );

    // Output register: load on accept (even while draining), empty on a
    // drain with nothing new, otherwise hold the word stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            out_data <= '0;
            out_src  <= SRC_1;
        end else if (accept) begin
            state    <= FULL;
            out_data <= acc_2 ? in2_data : in1_data;
            out_src  <= acc_2 ? SRC_2 : SRC_1;
        end else if (out_ready) begin
            state    <= EMPTY;
        end
    end

endmodule

// File: tb/tb_merge_2_to_1_10bits.sv
// Bench for merge_2_to_1_10bits. Expected words are queued when the bench
// sees an input accepted; a separate monitor pops and compares whenever the
// output is drained. Works with or without MERGE_RR_ARB_EN defined.
`timescale 1ns/1ps

module tb_merge_2_to_1_10bits;

    localparam int DW = 10;

`ifdef MERGE_RR_ARB_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in1_valid;
    logic          in1_ready;
    logic [DW-1:0] in1_data;
    logic          in2_valid;
    logic          in2_ready;
    logic [DW-1:0] in2_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_src;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Expected output words, {src, data}, in acceptance order
    logic [DW:0] exp_q[$];
    logic [DW:0] mon_exp;

    // Reference state: output register occupancy, last winner (1 = source 2)
    bit m_full;
    bit m_last;
    bit last_acc1;
    bit last_acc2;

    // Random stimulus holding registers
    logic          r_v1;
    logic          r_v2;
    logic          r_ordy;
    logic [DW-1:0] r_d1;
    logic [DW-1:0] r_d2;
    logic          exp_src;

    merge_2_to_1_10bits #(.DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .in1_data  (in1_data),
        .in2_valid (in2_valid),
        .in2_ready (in2_ready),
        .in2_data  (in2_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src)
    );

    // Free-running 10 ns clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, check the readies and
    // out_valid against the reference, and queue whatever gets accepted.
    task automatic applyStimulus(input logic v1, input logic [DW-1:0] d1,
                                 input logic v2, input logic [DW-1:0] d2,
                                 input logic ordy);
        bit free, g1, g2, r1, r2, a1, a2;
        @(negedge clk);
        in1_valid = v1;
        in1_data  = d1;
        in2_valid = v2;
        in2_data  = d2;
        out_ready = ordy;
        #1;
        free = !m_full || ordy;
        if (v1 && v2) begin
            g1 = RR ? m_last : 1'b1;
            g2 = !g1;
        end else begin
            g1 = v1;
            g2 = v2;
        end
        r1 = free && g1;
        r2 = free && g2;
        checkOutput("out_valid", 16'(out_valid), 16'(m_full));
        checkOutput("in1_ready", 16'(in1_ready), 16'(r1));
        checkOutput("in2_ready", 16'(in2_ready), 16'(r2));
        a1 = v1 && r1;
        a2 = v2 && r2;
        if (a1)
            exp_q.push_back({1'b0, d1});
        else if (a2)
            exp_q.push_back({1'b1, d2});
        if (a1 || a2)
            m_last = a2;
        m_full    = a1 || a2 || (m_full && !ordy);
        last_acc1 = a1;
        last_acc2 = a2;
    endtask

    // Assert reset mid-cycle, check the outputs clear at once, drop any
    // queued word, then release on the next falling edge.
    task automatic doReset();
        @(negedge clk);
        #3;
        rst_n     = 1'b0;
        in1_valid = 1'b0;
        in2_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        checkOutput("rst_out_valid", 16'(out_valid), 16'h0);
        checkOutput("rst_out_data",  16'(out_data),  16'h0);
        checkOutput("rst_out_src",   16'(out_src),   16'h0);
        checkOutput("rst_in1_ready", 16'(in1_ready), 16'h0);
        checkOutput("rst_in2_ready", 16'(in2_ready), 16'h0);
        exp_q.delete();
        m_full = 1'b0;
        m_last = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: whenever a word leaves the DUT, it must be the oldest queued one
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("[TB] FAIL unexpected_output: got data 0x%0h src %0d, expected no word",
                             out_data, out_src);
                end else begin
                    mon_exp = exp_q.pop_front();
                    checkOutput("sb_out_data", 16'(out_data), 16'(mon_exp[DW-1:0]));
                    checkOutput("sb_out_src",  16'(out_src),  16'(mon_exp[DW]));
                end
            end
        end
    end

    // Runaway guard
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "[TB] timeout");
    end

    // Directed scenarios followed by a long random run
    initial begin
        rst_n     = 1'b1;
        in1_valid = 1'b0;
        in1_data  = '0;
        in2_valid = 1'b0;
        in2_data  = '0;
        out_ready = 1'b0;
        m_full    = 1'b0;
        m_last    = 1'b1;
        last_acc1 = 1'b0;
        last_acc2 = 1'b0;
        doReset();

        // Single word from source 1, visible the next cycle
        $display("[TB] single word from source 1");
        applyStimulus(1'b1, 10'h155, 1'b0, 10'h000, 1'b1);
        applyStimulus(1'b0, 10'h000, 1'b0, 10'h000, 1'b1);
        checkOutput("t1_out_valid", 16'(out_valid), 16'h1);
        checkOutput("t1_out_data",  16'(out_data),  16'h155);
        checkOutput("t1_out_src",   16'(out_src),   16'h0);
        applyStimulus(1'b0, 10'h000, 1'b0, 10'h000, 1'b1);

        // Continuous contention: alternation with round-robin, source 1 only otherwise
        $display("[TB] continuous contention");
        doReset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 10'h001, 1'b1, 10'h3FF, 1'b1);
            if (i > 0) begin
                exp_src = RR ? logic'((i - 1) % 2) : 1'b0;
                checkOutput("contend_src",  16'(out_src),  16'(exp_src));
                checkOutput("contend_data", 16'(out_data), exp_src ? 16'h3FF : 16'h001);
            end
        end
        applyStimulus(1'b0, 10'h000, 1'b0, 10'h000, 1'b1);
        applyStimulus(1'b0, 10'h000, 1'b0, 10'h000, 1'b1);

        // Back-pressure: word held five cycles, then drain and refill together
        $display("[TB] output stall");
        doReset();
        applyStimulus(1'b1, 10'h2AA, 1'b0, 10'h000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 10'h0F0, 1'b0, 10'h000, 1'b0);
            checkOutput("stall_data",      16'(out_data),  16'h2AA);
            checkOutput("stall_in1_ready", 16'(in1_ready), 16'h0);
        end
        applyStimulus(1'b1, 10'h0F0, 1'b0, 10'h000, 1'b1);
        applyStimulus(1'b0, 10'h000, 1'b0, 10'h000, 1'b1);
        checkOutput("after_stall_data",  16'(out_data),  16'h0F0);
        checkOutput("after_stall_valid", 16'(out_valid), 16'h1);
        applyStimulus(1'b0, 10'h000, 1'b0, 10'h000, 1'b1);

        // Reset while a word is held: it must vanish
        $display("[TB] reset while full");
        applyStimulus(1'b0, 10'h000, 1'b1, 10'h1C3, 1'b0);
        applyStimulus(1'b0, 10'h000, 1'b0, 10'h000, 1'b0);
        checkOutput("held_data", 16'(out_data), 16'h1C3);
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 10'h000, 1'b0, 10'h000, 1'b1);
            checkOutput("post_rst_valid", 16'(out_valid), 16'h0);
        end

        // Random valid/ready traffic; a source keeps its word until accepted
        $display("[TB] random traffic");
        r_v1 = 1'b0;
        r_v2 = 1'b0;
        r_d1 = '0;
        r_d2 = '0;
        for (int i = 0; i < 10000; i++) begin
            if (!r_v1 || last_acc1) begin
                r_v1 = ($urandom_range(0, 3) != 0);
                r_d1 = 10'($urandom_range(0, 1023));
            end
            if (!r_v2 || last_acc2) begin
                r_v2 = ($urandom_range(0, 3) != 0);
                r_d2 = 10'($urandom_range(0, 1023));
            end
            r_ordy = ($urandom_range(0, 3) != 0);
            applyStimulus(r_v1, r_d1, r_v2, r_d2, r_ordy);
        end
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b0, 10'h000, 1'b0, 10'h000, 1'b1);
        checkOutput("queue_empty", 16'(exp_q.size()), 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
